// File: rtl/uart_ctrl.sv
// uart_ctrl: single-clock UART; bit timing from clk by an internal divider, TX/RX FIFOs, sticky errors.
// Latency: a word pushed into an empty TX FIFO drives the start bit from the second edge after tx_en; an RX pop returns rx_data one cycle after rx_en.
// Backpressure: a push into a full TX FIFO is ignored; a received frame that finds the RX FIFO full is dropped and flagged in rx_overrun.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   tx_en, tx_data    push a word into the TX FIFO
//   tx_full, tx_count TX FIFO status
//   tx_busy, tx       TX FSM not idle; serial out (idles high)
//   rx                serial in (asynchronous, synchronised internally)
//   rx_en             pop one word from the RX FIFO
//   rx_data, rx_valid registered popped word and its 1-cycle qualifier
//   rx_count          RX FIFO occupancy
//   rx_overrun        sticky: completed frame dropped, RX FIFO full
//   rx_frame_err      sticky: stop bit sampled low
//   rx_parity_err     sticky: parity mismatch (only with UART_PARITY_EN)
//   clr_err           clears all sticky flags, wins over a same-cycle set
//
// Optional feature macro: UART_PARITY_EN adds parameter PARITY_ODD, a parity bit between
// the data bits and the stop bit on both directions, and output rx_parity_err.

// uart_ctrl_fifo: circular FIFO, 2**AW words, count/full/empty status.
// Latency: head word visible combinationally; push/pop take effect on the next edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module uart_ctrl_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push_vld,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop_rdy,
    output logic [DW-1:0] o_head_dat,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full     = (r_count == CNT_FULL);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_pop      = i_pop_rdy && !o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push     = i_push_vld && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a word is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module uart_ctrl #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
`ifdef UART_PARITY_EN
    parameter bit PARITY_ODD   = 1'b0,
`endif
    parameter int FIFO_AW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic [FIFO_AW:0]     tx_count,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic [FIFO_AW:0]     rx_count,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
`ifdef UART_PARITY_EN
    output logic                 rx_parity_err,
`endif
    input  logic                 clr_err
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_ONE  = 1;
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- TX path
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_empty;
    logic                 w_tx_pop;
    logic                 w_tx_bit_end;

    state_t               r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    uart_ctrl_fifo #(
        .DW (DATA_BITS),
        .AW (FIFO_AW)
    ) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (tx_en),
        .i_push_dat (tx_data),
        .i_pop_rdy  (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_count    (tx_count),
        .o_full     (tx_full),
        .o_empty    (w_tx_empty)
    );

    // A new word is taken from IDLE, or on the last cycle of STOP so frames run back to back.
    always_comb begin
        w_tx_bit_end = (r_tx_cnt == C_LAST);
        w_tx_pop     = !w_tx_empty &&
                       ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_bit_end));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_tx_cnt <= '0;
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
                        r_tx_par   <= (^w_tx_head) ^ PARITY_ODD;
`endif
                        r_tx       <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == B_LAST) begin
`ifdef UART_PARITY_EN
                            r_tx       <= r_tx_par;
                            r_tx_state <= S_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
`endif
                        end else begin
                            r_tx_bit   <= r_tx_bit + B_ONE;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b1;
                        r_tx_state <= S_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (w_tx_pop) begin
                            r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
                            r_tx_par   <= (^w_tx_head) ^ PARITY_ODD;
`endif
                            r_tx       <= 1'b0;
                            r_tx_state <= S_START;
                        end else begin
                            r_tx_state <= S_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
                default: begin
                    r_tx_state <= S_IDLE;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = (r_tx_state != S_IDLE);

    // ---------------------------------------------------------------- RX path
    logic                 r_rx_s1;
    logic                 r_rx_s2;
    state_t               r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [BW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_hold;
    logic                 r_rx_ovr;
    logic                 r_rx_ferr;
`ifdef UART_PARITY_EN
    logic                 r_rx_par_bad;
    logic                 r_rx_perr;
`endif
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;

    logic [DATA_BITS-1:0] w_rx_head;
    logic                 w_rx_empty;
    logic                 w_rx_full;
    logic                 w_rx_smp;
    logic                 w_rx_push;
    logic                 w_rx_ovr;
    logic                 w_rx_pop;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    always_comb begin
        w_rx_smp  = (r_rx_cnt == '0);
        w_rx_push = (r_rx_state == S_STOP) && !r_rx_hold && w_rx_smp && r_rx_s2
`ifdef UART_PARITY_EN
                    && !r_rx_par_bad
`endif
                    ;
        w_rx_pop  = rx_en && !w_rx_empty;
        // With a full FIFO the push only lands if rx_en frees a slot this cycle.
        w_rx_ovr  = w_rx_push && w_rx_full && !rx_en;
    end

    uart_ctrl_fifo #(
        .DW (DATA_BITS),
        .AW (FIFO_AW)
    ) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_rx_push),
        .i_push_dat (r_rx_shift),
        .i_pop_rdy  (rx_en),
        .o_head_dat (w_rx_head),
        .o_count    (rx_count),
        .o_full     (w_rx_full),
        .o_empty    (w_rx_empty)
    );

    // The counter runs down: loaded with half a bit on the start edge, then with a
    // full bit after every sample, so each sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_hold    <= 1'b0;
            r_rx_ovr     <= 1'b0;
            r_rx_ferr    <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
            r_rx_perr    <= 1'b0;
`endif
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_cnt   <= C_HALF;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_rx_smp) begin
                        if (r_rx_s2) begin
                            r_rx_state <= S_IDLE;   // glitch shorter than half a bit
                        end else begin
                            r_rx_cnt   <= C_LAST;
                            r_rx_bit   <= '0;
                            r_rx_state <= S_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - C_ONE;
                    end
                end
                S_DATA: begin
                    if (w_rx_smp) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_cnt   <= C_LAST;
                        if (r_rx_bit == B_LAST) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= S_PARITY;
`else
                            r_rx_state <= S_STOP;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + B_ONE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - C_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_rx_smp) begin
                        r_rx_par_bad <= (r_rx_s2 != ((^r_rx_shift) ^ PARITY_ODD));
                        if (r_rx_s2 != ((^r_rx_shift) ^ PARITY_ODD)) r_rx_perr <= 1'b1;
                        r_rx_cnt   <= C_LAST;
                        r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - C_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (r_rx_hold) begin
                        // Broken stop bit: wait for the line to return high.
                        if (r_rx_s2) begin
                            r_rx_hold  <= 1'b0;
                            r_rx_state <= S_IDLE;
                        end
                    end else if (w_rx_smp) begin
                        if (r_rx_s2) begin
                            if (w_rx_ovr) r_rx_ovr <= 1'b1;
                            r_rx_state <= S_IDLE;
                        end else begin
                            r_rx_ferr <= 1'b1;
                            r_rx_hold <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - C_ONE;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase

            // Placed last so the clear overrides any set in the same cycle.
            if (clr_err) begin
                r_rx_ovr  <= 1'b0;
                r_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
                r_rx_perr <= 1'b0;
`endif
            end
        end
    end

    // Registered pop result; rx_data keeps its last value between pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_rx_pop;
            if (w_rx_pop) r_rx_data <= w_rx_head;
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_overrun   = r_rx_ovr;
    assign rx_frame_err = r_rx_ferr;
`ifdef UART_PARITY_EN
    assign rx_parity_err = r_rx_perr;
`endif
endmodule
